// File: rtl/data_memory_mmio.sv
// Data-side memory stage: word RAM plus a 16-byte MMIO window (CYCLE, GPIO, STATUS, GPIO_IN/reserved).
// Optional macro DMEM_GPIO_IN_EN adds a synchronized gpio_in port readable at MMIO offset +0xC.
module data_memory_mmio #(
  parameter int          DEPTH     = 256,
  parameter logic [31:0] MMIO_BASE = 32'hFFFF_0000,
  parameter int          GPIO_W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  input  logic              we,
`ifdef DMEM_GPIO_IN_EN
  input  logic [GPIO_W-1:0] gpio_in,
`endif
  output logic [31:0]       rdata,
  output logic [GPIO_W-1:0] gpio_out,
  output logic              err
);

  localparam int AW = $clog2(DEPTH);

  logic [31:0]       mem [DEPTH];
  logic [31:0]       cycle_cnt;
  logic [1:0]        status;
  logic [AW-1:0]     idx;
  logic [1:0]        offset;
  logic              misaligned;
  logic              in_ram;
  logic              in_mmio;
  logic              unmapped;
  logic              set_misalign;
  logic              set_unmapped;
  logic              wr_cycle;
  logic              wr_gpio;
  logic              wr_status;
  logic [1:0]        status_clr;
  logic [GPIO_W-1:0] gpio_rd;

  // Decode priority: alignment first, then RAM, then MMIO window, else unmapped.
  assign misaligned = (addr[1:0] != 2'b00);
  assign in_ram     = !misaligned && (addr[31:AW+2] == '0);
  assign in_mmio    = !misaligned && !in_ram && (addr[31:4] == MMIO_BASE[31:4]);
  assign unmapped   = !misaligned && !in_ram && !in_mmio;
  assign idx        = addr[AW+1:2];
  assign offset     = addr[3:2];

  assign set_misalign = we && misaligned;
  assign set_unmapped = we && unmapped;
  assign wr_cycle     = we && in_mmio && (offset == 2'd0);
  assign wr_gpio      = we && in_mmio && (offset == 2'd1);
  assign wr_status    = we && in_mmio && (offset == 2'd2);
  assign status_clr   = wr_status ? wdata[1:0] : 2'b00;

  // RAM has no reset; rst still blocks a store presented while reset is held.
  always_ff @(posedge clk) begin
    if (rst && we && in_ram) begin
      mem[idx] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cycle_cnt <= '0;
      gpio_out  <= '0;
      status    <= '0;
    end else begin
      cycle_cnt <= wr_cycle ? 32'd0 : cycle_cnt + 32'd1;
      if (wr_gpio) begin
        gpio_out <= wdata[GPIO_W-1:0];
      end
      // A new error event beats a write-1-to-clear on the same bit.
      status <= (status & ~status_clr) | {set_unmapped, set_misalign};
    end
  end

  assign err = status[1] | status[0];

`ifdef DMEM_GPIO_IN_EN
  logic [GPIO_W-1:0] gpio_meta;
  logic [GPIO_W-1:0] gpio_sync;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gpio_meta <= '0;
      gpio_sync <= '0;
    end else begin
      gpio_meta <= gpio_in;
      gpio_sync <= gpio_meta;
    end
  end

  assign gpio_rd = gpio_sync;
`else
  assign gpio_rd = '0;
`endif

  always_comb begin
    rdata = '0;
    if (in_ram) begin
      rdata = mem[idx];
    end else if (in_mmio) begin
      case (offset)
        2'd0:    rdata = cycle_cnt;
        2'd1:    rdata[GPIO_W-1:0] = gpio_out;
        2'd2:    rdata[1:0] = status;
        default: rdata[GPIO_W-1:0] = gpio_rd;
      endcase
    end
  end

endmodule

// File: tb/tb_data_memory_mmio.sv
// Directed self-checking bench for data_memory_mmio (DEPTH=256, MMIO_BASE=FFFF_0000, GPIO_W=8).
module tb_data_memory_mmio;

  localparam logic [31:0] BASE = 32'hFFFF_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        we;
  logic [31:0] rdata;
  logic [7:0]  gpio_out;
  logic        err;
`ifdef DMEM_GPIO_IN_EN
  logic [7:0]  gpio_in;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] c0;

  always #5 clk = ~clk;

  data_memory_mmio #(.DEPTH(256), .MMIO_BASE(32'hFFFF_0000), .GPIO_W(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .addr     (addr),
    .wdata    (wdata),
    .we       (we),
`ifdef DMEM_GPIO_IN_EN
    .gpio_in  (gpio_in),
`endif
    .rdata    (rdata),
    .gpio_out (gpio_out),
    .err      (err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    addr  = a;
    wdata = d;
    we    = 1'b1;
    @(posedge clk);
    #1;
    we = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a);
    addr = a;
    we   = 1'b0;
    #1;
  endtask

  initial begin
    rst   = 1'b0;
    addr  = 32'h0;
    wdata = 32'h0;
    we    = 1'b0;
`ifdef DMEM_GPIO_IN_EN
    gpio_in = 8'h00;
`endif

    // 1. reset, RAM access
    repeat (2) @(posedge clk);
    #1;
    check("reset_gpio", {24'h0, gpio_out}, 32'h0);
    check("reset_err", {31'h0, err}, 32'h0);
    rd(BASE + 32'h8);
    check("reset_status", rdata, 32'h0);
    rst = 1'b1;
    wr(32'h10, 32'hDEAD_BEEF);
    rd(32'h10);
    check("ram_rd_0x10", rdata, 32'hDEAD_BEEF);
    wr(32'h3FC, 32'h1234_5678);
    rd(32'h3FC);
    check("ram_rd_last", rdata, 32'h1234_5678);
    rd(32'h10);
    check("ram_keep_0x10", rdata, 32'hDEAD_BEEF);
    check("t1_gpio", {24'h0, gpio_out}, 32'h0);
    check("t1_err", {31'h0, err}, 32'h0);

    // 2. misaligned and unmapped errors
    wr(32'h11, 32'hCAFE_F00D);
    check("misalign_err", {31'h0, err}, 32'h1);
    rd(BASE + 32'h8);
    check("misalign_status", rdata, 32'h1);
    rd(32'h10);
    check("misalign_ram_untouched", rdata, 32'hDEAD_BEEF);
    rd(32'h11);
    check("misalign_rd_zero", rdata, 32'h0);
    wr(BASE + 32'h8, 32'h1);
    rd(BASE + 32'h8);
    check("w1c_status", rdata, 32'h0);
    check("w1c_err", {31'h0, err}, 32'h0);
    wr(32'h400, 32'h0BAD_0BAD);
    rd(BASE + 32'h8);
    check("unmapped_status", rdata, 32'h2);
    check("unmapped_err", {31'h0, err}, 32'h1);
    rd(32'h400);
    check("unmapped_rd_zero", rdata, 32'h0);
    @(posedge clk);
    #1;
    rd(BASE + 32'h8);
    check("unmapped_rd_no_set", rdata, 32'h2);
    wr(BASE + 32'h8, 32'h3);
    check("clear_all_err", {31'h0, err}, 32'h0);

    // 3. cycle counter
    rd(BASE);
    c0 = rdata;
    @(posedge clk);
    #1;
    check("cycle_incr", rdata, c0 + 32'd1);
    wr(BASE, 32'h5555_5555);
    check("cycle_clear", rdata, 32'h0);
    @(posedge clk);
    #1;
    check("cycle_after_clear", rdata, 32'h1);
    force dut.cycle_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.cycle_cnt;
    #1;
    check("cycle_forced", rdata, 32'hFFFF_FFFF);
    @(posedge clk);
    #1;
    check("cycle_wrap", rdata, 32'h0);

    // 4. GPIO and async reset
    wr(BASE + 32'h4, 32'hFFFF_FFA5);
    check("gpio_out", {24'h0, gpio_out}, 32'h0000_00A5);
    rd(BASE + 32'h4);
    check("gpio_rd", rdata, 32'h0000_00A5);
    #1;
    rst = 1'b0;
    #1;
    check("gpio_async_reset", {24'h0, gpio_out}, 32'h0);
    rd(BASE);
    check("cycle_async_reset", rdata, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // 5. set beats clear
    wr(32'h1, 32'h0);
    rd(BASE + 32'h8);
    check("misalign2_status", rdata, 32'h1);
    check("misalign2_err", {31'h0, err}, 32'h1);
    addr  = BASE + 32'h8;
    wdata = 32'h1;
    we    = 1'b1;
    force dut.set_misalign = 1'b1;
    @(posedge clk);
    #1;
    release dut.set_misalign;
    we = 1'b0;
    #1;
    check("set_wins_status", rdata, 32'h1);
    check("set_wins_err", {31'h0, err}, 32'h1);
    wr(BASE + 32'h8, 32'h1);
    check("clear_after_collision", rdata, 32'h0);

    // 6. +0xC
`ifdef DMEM_GPIO_IN_EN
    rd(BASE + 32'hC);
    gpio_in = 8'h3C;
    @(posedge clk);
    #1;
    check("gpio_in_1edge", rdata, 32'h0);
    @(posedge clk);
    #1;
    check("gpio_in_2edge", rdata, 32'h0000_003C);
`else
    rd(BASE + 32'hC);
    check("reserved_rd", rdata, 32'h0);
`endif
    wr(BASE + 32'hC, 32'hFFFF_FFFF);
    check("reserved_wr_no_err", {31'h0, err}, 32'h0);
    rd(BASE + 32'h4);
    check("reserved_wr_gpio_kept", rdata, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/data_memory_mmio.md
Name: data_memory_mmio

Overview:
Data-side memory stage directly downstream of the single-cycle MIPS32 core. It consumes the core's data address, write data and write-enable, and returns read data in the same cycle.
- Contains a word-addressed RAM.
- Contains a small memory-mapped register window: cycle counter, GPIO output, error status.
- Reads are combinational, so the single-cycle core's load path closes in one clock. All state updates happen on the rising clock edge.

Parameters:
DEPTH, 256, RAM size in 32-bit words; must be a power of two, minimum 4.
MMIO_BASE, 32'hFFFF_0000, byte base address of the 16-byte register window; 16-byte aligned.
GPIO_W, 8, width of the GPIO output register.

Ports:
clk  in  1  clock, rising-edge active
rst  in  1  asynchronous, active-low reset
addr  in  32  byte address (core addressData)
wdata  in  32  store data (core writeData)
we  in  1  store strobe (core we)
rdata  out  32  load data (to core readData), combinational
gpio_out  out  GPIO_W  GPIO output register
err  out  1  OR of sticky error bits

Behaviour:
Reset:
- rst low asynchronously clears counter, gpio_out, and err bits [1:0] to 0.
- RAM contents are not reset.
- rst has priority over any write in the same cycle.

Address decode, first match wins:
1. Misaligned, addr[1:0] != 0:
   - rdata = 0.
   - A write is dropped and sets err bit0 (MISALIGN).
2. RAM, addr < 4*DEPTH:
   - Word index is addr[log2(DEPTH)+1:2].
   - Read: rdata = ram[idx] combinationally, valid in the same cycle.
   - Write: ram[idx] <= wdata at the edge.
   - Read-during-write to the same address returns the old word until the edge.
3. MMIO, MMIO_BASE <= addr < MMIO_BASE+16:
   - +0x0 CYCLE: 32-bit free-running counter, +1 every cycle, wraps 32'hFFFF_FFFF -> 0.
     - Read returns the current value.
     - Any write loads 0 at that edge; the clear takes priority over the increment.
   - +0x4 GPIO: R/W.
     - Write loads wdata[GPIO_W-1:0].
     - Read returns the value zero-extended.
   - +0x8 STATUS: bit0 MISALIGN, bit1 UNMAPPED, upper bits 0.
     - Write-1-to-clear per bit.
     - If a clear and a new error event hit the same bit in the same cycle, set wins.
   - +0xC: RESERVED, or GPIO_IN when DMEM_GPIO_IN_EN is defined.
     - Reserved: reads 0, writes ignored, no error flagged.
4. Anything else:
   - rdata = 0.
   - A write is dropped and sets err bit1 (UNMAPPED).
   - Reads never set error bits.

Outputs and timing:
- err = STATUS[1] | STATUS[0], registered.
- Only a write (we=1) can set an error bit.
- Error set latency: err rises one edge after the offending write.
- With we=0, no state changes except CYCLE increment.

Optional Feature:
Macro DMEM_GPIO_IN_EN.

Defined:
- Adds port gpio_in, in, GPIO_W.
- gpio_in passes through a 2-flop synchronizer, both flops reset to 0.
- Offset +0xC reads the synchronized value zero-extended; writes there are ignored.
- An input change is visible at +0xC after 2 rising edges.

Undefined:
- No gpio_in port, no synchronizer flops.
- +0xC reads 0.

Test Plan:
1. Reset then RAM access: hold rst low 2 cycles, release; write 32'hDEAD_BEEF to addr 0x10, next cycle read 0x10 -> rdata=32'hDEAD_BEEF; read 0x3FC (DEPTH=256, last word) after writing 32'h1234_5678 there -> 32'h1234_5678; gpio_out=0 and err=0 throughout.
2. Misaligned and unmapped errors: write to 0x11 -> RAM word 0x10 unchanged, err=1 next cycle, STATUS=1; write 32'h1 to MMIO_BASE+8 -> STATUS=0, err=0; write to 0x400 -> STATUS=2; read 0x400 -> rdata=0 with STATUS unchanged.
3. Cycle counter: after reset, read CYCLE on consecutive cycles -> values differ by 1; write any data to MMIO_BASE+0 -> next read = 1; force counter to 32'hFFFF_FFFF via bench hierarchy -> wraps to 0 on the next edge.
4. GPIO: write 32'hFFFF_FFA5 to MMIO_BASE+4 -> gpio_out=8'hA5, read returns 32'h0000_00A5; assert rst low mid-cycle -> gpio_out=0 immediately, before any clock edge.
5. Same-cycle collision: with STATUS=1, issue a misaligned write to 0x1 -> err bit0 set; then, with STATUS bit0 still set, write 32'h1 to STATUS in the cycle a misaligned access is presented -> only one write per cycle is possible, so the bench verifies via forced internal event that set wins and STATUS bit0 stays 1.
6. DMEM_GPIO_IN_EN: drive gpio_in=8'h3C -> read MMIO_BASE+0xC returns 0 after 1 edge and 32'h3C after 2 edges; without the macro, reading +0xC returns 0 and writing +0xC leaves err=0.
